// File: rtl/booth_pkg.sv
// Shared Booth select-code definitions. The datapath mux imports this package too, so the
// order of its mux inputs always matches these codes.
package booth_pkg;

  localparam logic [2:0] SEL_ZERO = 3'd0;
  localparam logic [2:0] SEL_P1   = 3'd1;
  localparam logic [2:0] SEL_P2   = 3'd2;
  localparam logic [2:0] SEL_N1   = 3'd3;
  localparam logic [2:0] SEL_N2   = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  // Signed multiple of M selected by a code; illegal codes map to zero.
  function automatic int sel_value(input logic [2:0] code);
    case (code)
      SEL_P1:  sel_value = 1;
      SEL_P2:  sel_value = 2;
      SEL_N1:  sel_value = -1;
      SEL_N2:  sel_value = -2;
      default: sel_value = 0;
    endcase
  endfunction

  function automatic logic sel_is_legal(input logic [2:0] code);
    sel_is_legal = (code <= SEL_N2);
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth digit encoder: maps the triplet {b[2i+1], b[2i], b[2i-1]} to a select code.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0] triplet_i,
  output logic [2:0] sel_o
);

  always_comb begin
    sel_o = SEL_ZERO;
    case (triplet_i)
      3'b000:  sel_o = SEL_ZERO;
      3'b001:  sel_o = SEL_P1;
      3'b010:  sel_o = SEL_P1;
      3'b011:  sel_o = SEL_P2;
      3'b100:  sel_o = SEL_N2;
      3'b101:  sel_o = SEL_N1;
      3'b110:  sel_o = SEL_N1;
      3'b111:  sel_o = SEL_ZERO;
      default: sel_o = SEL_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_sel_gen.sv
// Sequential radix-4 Booth recoder: streams one select code per digit, LSD first, over a
// valid/ready handshake.
module booth_sel_gen
  import booth_pkg::*;
#(
  parameter int unsigned W = 8,
  localparam int unsigned N = W / 2,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    mplr,
  output logic            idle,
  output logic [2:0]      sel,
  output logic            sel_valid,
  input  logic            sel_ready,
  output logic [IdxW-1:0] digit_idx,
  output logic            last,
  output logic            done
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  booth_state_t    state_q;
  logic [W:0]      sr_q;
  logic [2:0]      triplet;
  logic [2:0]      enc_sel;
  logic [W:0]      sr_shift;
  logic [IdxW-1:0] idx_next;
  logic            unused_sr_low;

  // In IDLE the encoder looks at the incoming operand so digit 0 is registered on the load
  // edge; in RUN it looks one digit ahead of the one currently presented.
  assign triplet  = (state_q == IDLE) ? {mplr[1:0], 1'b0} : sr_q[4:2];
  assign sr_shift = {{2{sr_q[W]}}, sr_q[W:2]};
  assign idx_next = digit_idx + 1'b1;
  assign idle     = (state_q == IDLE);

  // The two low bits only hold the digit already on the output.
  assign unused_sr_low = ^sr_q[1:0];

  booth_digit_enc u_enc (
    .triplet_i (triplet),
    .sel_o     (enc_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      sel       <= SEL_ZERO;
      sel_valid <= 1'b0;
      digit_idx <= '0;
      last      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_q   <= RUN;
            sr_q      <= {mplr, 1'b0};
            sel       <= enc_sel;
            sel_valid <= 1'b1;
            digit_idx <= '0;
            last      <= (LastIdx == '0);
          end
        end
        RUN: begin
          if (sel_ready) begin
            if (last) begin
              state_q   <= DONE;
              sr_q      <= '0;
              sel       <= SEL_ZERO;
              sel_valid <= 1'b0;
              digit_idx <= '0;
              last      <= 1'b0;
              done      <= 1'b1;
            end else begin
              sr_q      <= sr_shift;
              sel       <= enc_sel;
              digit_idx <= idx_next;
              last      <= (idx_next == LastIdx);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          sel       <= SEL_ZERO;
          sel_valid <= 1'b0;
          digit_idx <= '0;
          last      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_sel_gen.sv
// Directed and randomised checks of the Booth select stream, handshake timing and reset.
module tb_booth_sel_gen;

  localparam int W = 8;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sel_ready = 1'b0;
  logic [7:0] mplr = '0;
  logic       idle, sel_valid, last, done;
  logic [2:0] sel;
  logic [1:0] digit_idx;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  booth_sel_gen #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mplr      (mplr),
    .idle      (idle),
    .sel       (sel),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .digit_idx (digit_idx),
    .last      (last),
    .done      (done)
  );

  typedef struct {
    logic [7:0]      m;
    logic [3:0][2:0] s;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [7:0] m, input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] c, input logic [2:0] d);
    vec_t v;
    v.m = m;
    v.s[0] = a;
    v.s[1] = b;
    v.s[2] = c;
    v.s[3] = d;
    return v;
  endfunction

  function automatic int code_val(input logic [2:0] c);
    case (c)
      3'd0: code_val = 0;
      3'd1: code_val = 1;
      3'd2: code_val = 2;
      3'd3: code_val = -1;
      3'd4: code_val = -2;
      default: code_val = 1000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " idle"}, 32'(idle), 1);
    chk({tag, " sel_valid"}, 32'(sel_valid), 0);
    chk({tag, " sel"}, 32'(sel), 0);
    chk({tag, " digit_idx"}, 32'(digit_idx), 0);
    chk({tag, " last"}, 32'(last), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  // One full sequence from IDLE; optional stall on one digit and stray starts in RUN/DONE.
  task automatic run_seq(input logic [7:0] m, input logic [3:0][2:0] exp, input int stall_d,
                         input int stall_n, input int inj_d, input bit inj_done,
                         input string tag);
    chk({tag, " idle before start"}, 32'(idle), 1);
    start = 1'b1;
    mplr = m;
    sel_ready = 1'b1;
    step();
    start = 1'b0;
    for (int d = 0; d < N; d++) begin
      if (d == stall_d) begin
        sel_ready = 1'b0;
        for (int c = 0; c < stall_n; c++) begin
          chk({tag, " stall valid"}, 32'(sel_valid), 1);
          chk({tag, " stall sel"}, 32'(sel), 32'(exp[d]));
          chk({tag, " stall idx"}, 32'(digit_idx), d);
          chk({tag, " stall done"}, 32'(done), 0);
          step();
        end
        sel_ready = 1'b1;
      end
      chk({tag, " valid"}, 32'(sel_valid), 1);
      chk({tag, " sel"}, 32'(sel), 32'(exp[d]));
      chk({tag, " idx"}, 32'(digit_idx), d);
      chk({tag, " last"}, 32'(last), (d == N - 1) ? 1 : 0);
      chk({tag, " done early"}, 32'(done), 0);
      if (d == inj_d) begin
        start = 1'b1;
        mplr = ~m;
      end
      step();
      start = 1'b0;
      mplr = m;
    end
    chk({tag, " done pulse"}, 32'(done), 1);
    chk({tag, " valid in done"}, 32'(sel_valid), 0);
    chk({tag, " sel in done"}, 32'(sel), 0);
    chk({tag, " idle in done"}, 32'(idle), 0);
    if (inj_done) begin
      start = 1'b1;
      mplr = 8'hFF;
    end
    step();
    start = 1'b0;
    chk({tag, " done cleared"}, 32'(done), 0);
    chk({tag, " idle after done"}, 32'(idle), 1);
    chk({tag, " valid after done"}, 32'(sel_valid), 0);
    if (inj_done) begin
      step();
      chk({tag, " start in done ignored"}, 32'(sel_valid), 0);
      chk({tag, " single done"}, 32'(done), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    int         sum, cnt, budget;
    bit         bad;

    vecs[0] = mk(8'h07, 3'd3, 3'd2, 3'd0, 3'd0);
    vecs[1] = mk(8'h80, 3'd0, 3'd0, 3'd0, 3'd4);
    vecs[2] = mk(8'hFF, 3'd3, 3'd0, 3'd0, 3'd0);
    vecs[3] = mk(8'h55, 3'd1, 3'd1, 3'd1, 3'd1);
    vecs[4] = mk(8'h7F, 3'd3, 3'd0, 3'd0, 3'd2);
    vecs[5] = mk(8'h2C, 3'd0, 3'd3, 3'd3, 3'd1);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    chk_reset_outputs("post-reset");

    foreach (vecs[i]) run_seq(vecs[i].m, vecs[i].s, -1, 0, -1, 1'b0, $sformatf("vec%0d", i));

    // Three stall cycles on digit 1 push done out by three cycles.
    run_seq(8'h07, vecs[0].s, 1, 3, -1, 1'b0, "stall");

    // Stray start in RUN (digit 1) and in DONE must be ignored.
    run_seq(8'h07, vecs[0].s, -1, 0, 1, 1'b1, "ignore");

    // Asynchronous reset while digit 2 is presented.
    start = 1'b1;
    mplr = 8'h07;
    sel_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre-reset idx", 32'(digit_idx), 2);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("no done after reset", 32'(done), 0);
      chk("no valid after reset", 32'(sel_valid), 0);
      step();
    end
    run_seq(8'h07, vecs[0].s, -1, 0, -1, 1'b0, "restart");

    // Random operands with random backpressure: the weighted digit sum must equal mplr.
    for (int v = 0; v < 1000; v++) begin
      m = 8'($urandom);
      sum = 0;
      cnt = 0;
      bad = 1'b0;
      budget = 0;
      start = 1'b1;
      mplr = m;
      step();
      start = 1'b0;
      while (!done && budget < 100) begin
        sel_ready = 1'($urandom_range(0, 1));
        if (sel_valid && sel_ready) begin
          if (sel > 3'd4) bad = 1'b1;
          if (digit_idx != cnt[1:0]) bad = 1'b1;
          if (last != (cnt == N - 1)) bad = 1'b1;
          sum += code_val(sel) * (1 << (2 * cnt));
          cnt++;
        end
        step();
        budget++;
      end
      chk("rand timeout", 32'(budget < 100), 1);
      chk("rand sum", 32'(sum), 32'(int'($signed(m))));
      chk("rand digits/legal", 32'((cnt == N) && !bad), 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
